// File: rtl/regfile_sb_pkg.sv
// Shared constants and types for the scoreboarded register file:
// default widths, counter operations and the CPU's register-index names.
package regfile_sb_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 4;
  localparam int unsigned DEF_CNT_W  = 2;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

  typedef enum logic [DEF_ADDR_W-1:0] {
    REG_ZERO = DEF_ADDR_W'(0),
    REG_RA   = DEF_ADDR_W'(1),
    REG_SP   = DEF_ADDR_W'(2),
    REG_GP   = DEF_ADDR_W'(3),
    REG_T0   = DEF_ADDR_W'(4),
    REG_T1   = DEF_ADDR_W'(5),
    REG_A0   = DEF_ADDR_W'(8),
    REG_A1   = DEF_ADDR_W'(9)
  } reg_idx_e;

endpackage

// File: rtl/regfile_sb_cnt.sv
// Saturating up/down pending-write counter for one register.
module regfile_sb_cnt
  import regfile_sb_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  cnt_op_e          op,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturate at both ends rather than wrap.
  always_comb begin
    cnt_d = cnt_q;
    case (op)
      CNT_INC: if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      CNT_DEC: if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, one writeback port and a
// per-register pending-write scoreboard feeding operand busy flags.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] addressIn,
  input  logic [DATA_W-1:0] regIn,
  input  logic [ADDR_W-1:0] addressA,
  input  logic [ADDR_W-1:0] addressB,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  input  logic              issue,
  input  logic [ADDR_W-1:0] issue_dest,
  output logic              busyA,
  output logic              busyB,
  output logic              issue_full,
  output logic              sb_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [CNT_W-1:0]  cnt   [DEPTH];
  logic              sb_err_q, sb_err_d;
  logic              wr_en, issue_ok;
  logic              zero_wr, zero_iss, zero_a, zero_b;
  logic              hit_a, hit_b;

  // Write/issue acceptance, array update and sticky scoreboard error.
  always_comb begin
    zero_wr    = ZERO_REG && (addressIn == ADDR_W'(REG_ZERO));
    zero_iss   = ZERO_REG && (issue_dest == ADDR_W'(REG_ZERO));
    wr_en      = we && !zero_wr;
    issue_full = issue && (cnt[issue_dest] == '1) &&
                 !(we && (addressIn == issue_dest));
    issue_ok   = issue && !issue_full && !zero_iss;
    mem_d      = mem_q;
    if (wr_en) mem_d[addressIn] = regIn;
    sb_err_d   = sb_err_q || (wr_en && (cnt[addressIn] == '0));
  end

  // Read ports; a writeback retiring the last pending write clears busy early.
  always_comb begin
    zero_a = ZERO_REG && (addressA == ADDR_W'(REG_ZERO));
    zero_b = ZERO_REG && (addressB == ADDR_W'(REG_ZERO));
    hit_a  = BYPASS && wr_en && (addressIn == addressA);
    hit_b  = BYPASS && wr_en && (addressIn == addressB);
    A      = hit_a ? regIn : (zero_a ? '0 : mem_q[addressA]);
    B      = hit_b ? regIn : (zero_b ? '0 : mem_q[addressB]);
    busyA  = (cnt[addressA] != '0) && !(hit_a && (cnt[addressA] == CNT_W'(1)));
    busyB  = (cnt[addressB] != '0) && !(hit_b && (cnt[addressB] == CNT_W'(1)));
  end

  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_cnt
    logic    inc, dec;
    cnt_op_e op;

    always_comb begin
      inc = issue_ok && (issue_dest == ADDR_W'(i));
      dec = wr_en && (addressIn == ADDR_W'(i));
      op  = CNT_HOLD;
      if (inc && !dec)      op = CNT_INC;
      else if (dec && !inc) op = CNT_DEC;
    end

    regfile_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (Clk),
      .reset (reset),
      .op    (op),
      .cnt   (cnt[i])
    );
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      sb_err_q <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      sb_err_q <= sb_err_d;
    end
  end

  assign sb_err = sb_err_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed and randomized checks of regfile_sb (bypass on and off) against
// an array/counter reference model.
module tb_regfile_sb;

  logic        Clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [3:0]  addressIn = '0;
  logic [31:0] regIn = '0;
  logic [3:0]  addressA = '0;
  logic [3:0]  addressB = '0;
  logic        issue = 1'b0;
  logic [3:0]  issue_dest = '0;

  logic [31:0] A, B, A_nb, B_nb;
  logic        busyA, busyB, issue_full, sb_err;
  logic        busyA_nb, busyB_nb, issue_full_nb, sb_err_nb;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [31:0] m_mem [16];
  int unsigned m_cnt [16];
  bit          m_err;

  always #5 Clk = ~Clk;

  regfile_sb dut (
    .Clk(Clk), .reset(reset), .we(we), .addressIn(addressIn), .regIn(regIn),
    .addressA(addressA), .addressB(addressB), .A(A), .B(B),
    .issue(issue), .issue_dest(issue_dest), .busyA(busyA), .busyB(busyB),
    .issue_full(issue_full), .sb_err(sb_err)
  );

  regfile_sb #(.BYPASS(1'b0)) dut_nb (
    .Clk(Clk), .reset(reset), .we(we), .addressIn(addressIn), .regIn(regIn),
    .addressA(addressA), .addressB(addressB), .A(A_nb), .B(B_nb),
    .issue(issue), .issue_dest(issue_dest), .busyA(busyA_nb), .busyB(busyB_nb),
    .issue_full(issue_full_nb), .sb_err(sb_err_nb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [3:0] a, input bit byp);
    if (a == 4'd0) return '0;
    if (byp && we && addressIn == a) return regIn;
    return m_mem[a];
  endfunction

  function automatic logic [31:0] exp_busy(input logic [3:0] a, input bit byp);
    if (a == 4'd0 || m_cnt[a] == 0) return '0;
    if (m_cnt[a] == 1 && byp && we && addressIn == a) return '0;
    return 32'd1;
  endfunction

  function automatic bit exp_full();
    return issue && issue_dest != 4'd0 && m_cnt[issue_dest] == 3 &&
           !(we && addressIn == issue_dest);
  endfunction

  // Reference update for one rising edge, from the inputs currently applied.
  task automatic model_step();
    bit w_ok, i_ok;
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        m_mem[i] = '0;
        m_cnt[i] = 0;
      end
      m_err = 1'b0;
    end else begin
      w_ok = we && addressIn != 4'd0;
      i_ok = issue && issue_dest != 4'd0 && !exp_full();
      if (w_ok) begin
        if (m_cnt[addressIn] == 0) m_err = 1'b1;
        m_mem[addressIn] = regIn;
      end
      if (!(w_ok && i_ok && addressIn == issue_dest)) begin
        if (i_ok) m_cnt[issue_dest] = m_cnt[issue_dest] + 1;
        if (w_ok && m_cnt[addressIn] > 0) m_cnt[addressIn] = m_cnt[addressIn] - 1;
      end
    end
  endtask

  task automatic check_all();
    chk("A",           A,                exp_rd(addressA, 1'b1));
    chk("B",           B,                exp_rd(addressB, 1'b1));
    chk("busyA",       32'(busyA),       exp_busy(addressA, 1'b1));
    chk("busyB",       32'(busyB),       exp_busy(addressB, 1'b1));
    chk("issue_full",  32'(issue_full),  32'(exp_full()));
    chk("sb_err",      32'(sb_err),      32'(m_err));
    chk("nb_A",        A_nb,             exp_rd(addressA, 1'b0));
    chk("nb_B",        B_nb,             exp_rd(addressB, 1'b0));
    chk("nb_busyA",    32'(busyA_nb),    exp_busy(addressA, 1'b0));
    chk("nb_busyB",    32'(busyB_nb),    exp_busy(addressB, 1'b0));
    chk("nb_full",     32'(issue_full_nb), 32'(exp_full()));
    chk("nb_sb_err",   32'(sb_err_nb),   32'(m_err));
  endtask

  task automatic drive(input logic rst, input logic w, input logic [3:0] ai,
                       input logic [31:0] d, input logic [3:0] aa, input logic [3:0] ab,
                       input logic iss, input logic [3:0] idst);
    @(posedge Clk);
    model_step();
    @(negedge Clk);
    reset = rst; we = w; addressIn = ai; regIn = d;
    addressA = aa; addressB = ab; issue = iss; issue_dest = idst;
    #1;
    check_all();
  endtask

  function automatic logic [3:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 4'($urandom_range(0, 15));
    return 4'($urandom_range(0, 3));
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) begin
      m_mem[i] = '0;
      m_cnt[i] = 0;
    end
    m_err = 1'b0;

    // Reset state
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 3, 9, 0, 0);
    chk("rst_A", A, 32'h0);
    chk("rst_busyA", 32'(busyA), 32'h0);
    chk("rst_sb_err", 32'(sb_err), 32'h0);

    // Basic writes and reads
    drive(0, 1, 3,  32'hABABFFFF, 0, 0, 0, 0);
    drive(0, 1, 5,  32'h15161718, 0, 0, 0, 0);
    drive(0, 1, 15, 32'h0045AB7F, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 3, 4, 0, 0);
    chk("rd_A3", A, 32'hABABFFFF);
    chk("rd_B4", B, 32'h0);
    drive(0, 0, 0, 0, 15, 5, 0, 0);
    chk("rd_A15", A, 32'h0045AB7F);
    chk("rd_B5", B, 32'h15161718);

    // Same-cycle forwarding
    drive(0, 1, 7, 32'hDEADBEEF, 7, 7, 0, 0);
    chk("byp_A7", A, 32'hDEADBEEF);
    chk("nobyp_A7", A_nb, 32'h0);

    // Register zero
    drive(0, 1, 0, 32'h12345678, 0, 0, 0, 0);
    chk("zero_wr_A", A, 32'h0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("zero_A", A, 32'h0);
    chk("zero_busyA", 32'(busyA), 32'h0);

    // Saturation at CNT_W=2 and drain
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 9, 9, 1, 9);
    drive(0, 0, 0, 0, 9, 9, 1, 9);
    drive(0, 0, 0, 0, 9, 9, 1, 9);
    drive(0, 0, 0, 0, 9, 9, 1, 9);
    chk("sat_full", 32'(issue_full), 32'h1);
    chk("sat_busyA", 32'(busyA), 32'h1);
    drive(0, 1, 9, 32'h00000091, 9, 9, 0, 0);
    drive(0, 1, 9, 32'h00000092, 9, 9, 0, 0);
    chk("drain_busy2", 32'(busyA), 32'h1);
    drive(0, 1, 9, 32'h00000093, 9, 9, 0, 0);
    chk("drain_busy3", 32'(busyA), 32'h0);
    chk("drain_nb_busy3", 32'(busyA_nb), 32'h1);
    drive(0, 0, 0, 0, 9, 9, 0, 0);
    chk("drain_err", 32'(sb_err), 32'h0);
    chk("drain_A9", A, 32'h00000093);

    // Simultaneous issue/we and writeback underflow
    drive(0, 0, 0, 0, 6, 6, 1, 6);
    drive(0, 1, 6, 32'h00000060, 6, 6, 1, 6);
    drive(0, 0, 0, 0, 6, 6, 0, 0);
    chk("simul_busyA", 32'(busyA), 32'h1);
    drive(0, 1, 6, 32'h00000061, 6, 6, 0, 0);
    drive(0, 1, 6, 32'hCAFE0006, 6, 6, 0, 0);
    drive(0, 0, 0, 0, 6, 6, 0, 0);
    chk("under_err", 32'(sb_err), 32'h1);
    chk("under_A6", A, 32'hCAFE0006);
    drive(0, 0, 0, 0, 1, 1, 0, 0);
    chk("under_sticky", 32'(sb_err), 32'h1);

    // Reset discards pending state and beats same-cycle we/issue
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 2, 2, 1, 2);
    drive(1, 1, 5, 32'h55555555, 2, 5, 1, 3);
    drive(0, 0, 0, 0, 2, 5, 0, 0);
    chk("rstp_busyA", 32'(busyA), 32'h0);
    chk("rstp_A2", A, 32'h0);
    chk("rstp_B5", B, 32'h0);
    chk("rstp_err", 32'(sb_err), 32'h0);
    drive(0, 1, 2, 32'h00000022, 2, 3, 0, 0);
    drive(0, 0, 0, 0, 2, 3, 0, 0);
    chk("rstp_err_after", 32'(sb_err), 32'h1);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      drive(logic'($urandom_range(0, 63) == 0), logic'($urandom_range(0, 1)),
            rnd_addr(), $urandom, rnd_addr(), rnd_addr(),
            logic'($urandom_range(0, 1)), rnd_addr());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4, address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter CNT_W, default 2, per-register pending-write counter width.
REQ-004 SHALL have parameter ZERO_REG, default 1; 1 = register 0 hardwired to zero.
REQ-005 SHALL have parameter BYPASS, default 1; 1 = same-cycle write-to-read forwarding.
REQ-006 SHALL have ports, one clock, reset synchronous and active-high:
- Clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- we  input  1  writeback enable, active-high
- addressIn  input  ADDR_W  writeback address
- regIn  input  DATA_W  writeback data
- addressA  input  ADDR_W  read port A address
- addressB  input  ADDR_W  read port B address
- A  output  DATA_W  read port A data
- B  output  DATA_W  read port B data
- issue  input  1  dispatch of an instruction with a destination
- issue_dest  input  ADDR_W  destination of issued instruction
- busyA  output  1  port A operand has a pending write
- busyB  output  1  port B operand has a pending write
- issue_full  output  1  issue_dest counter saturated; issue refused
- sb_err  output  1  sticky: writeback to register with zero pending count

Function
REQ-007 SHALL write regIn to register addressIn on the rising Clk edge when we=1.
REQ-008 SHALL drive A/B combinationally from the array; no read latency.
REQ-009 With ZERO_REG=1, SHALL ignore writes and issues to address 0, return 0 on reads of 0, and never assert busy for address 0.
REQ-010 With BYPASS=1, SHALL drive A=regIn when we=1 and addressIn=addressA (B likewise), except where REQ-009 applies; with BYPASS=0, SHALL return the old array value.
REQ-011 SHALL keep one CNT_W-bit pending counter per register: +1 on accepted issue, -1 on we.
REQ-012 Issue and we to the same register in one cycle SHALL leave its counter unchanged.
REQ-013 issue_full SHALL be combinational = issue AND counter[issue_dest] = all-ones AND NOT (we AND addressIn=issue_dest); when asserted, the issue SHALL be refused and the counter left unchanged.
REQ-014 we to a register with counter 0 SHALL still write data, keep the counter at 0 (no wrap), and set sb_err until reset.
REQ-015 busyA SHALL be 1 when counter[addressA] != 0, except 0 when it equals 1 and a same-cycle we targets addressA with BYPASS=1 (busyB likewise).
REQ-016 Counters SHALL never wrap in either direction.

Reset
REQ-017 On a Clk edge with reset=1, SHALL clear all registers, all counters and sb_err; A/B, busyA/B, issue_full and sb_err SHALL read 0 afterwards until new writes or issues.
REQ-018 reset SHALL take priority over we and issue in the same cycle; both are dropped.
REQ-019 reset while writes are pending SHALL discard the pending state; later we to those registers SHALL set sb_err (REQ-014).

Structure
REQ-020 The shared package SHALL hold default DATA_W/ADDR_W/CNT_W constants and the register-index constants used by the CPU.
REQ-021 The per-register saturating up/down counter SHALL be one sub-module, regfile_sb_cnt, instantiated 2**ADDR_W times via generate.

Verification
REQ-022 Reset, then we=1 writes 0xABABFFFF@3, 0x15161718@5, 0x0045AB7F@15; read A=3, B=4 -> A=0xABABFFFF, B=0; read A=15, B=5 -> A=0x0045AB7F, B=0x15161718.
REQ-023 we=1 addressIn=7 regIn=0xDEADBEEF with addressA=7 in the same cycle -> A=0xDEADBEEF that cycle with BYPASS=1; old value 0 with BYPASS=0.
REQ-024 Write 0x12345678 to address 0, read A=0 -> A=0; issue_dest=0 -> busyA stays 0.
REQ-025 Issue to 9 three times (CNT_W=2) -> busy on addressA=9; fourth issue -> issue_full=1, counter stays 3; three we@9 -> busyA drops in the cycle of the third we.
REQ-026 Simultaneous issue and we to 6 with counter 1 -> counter stays 1 and busyA stays 1; we@6 with counter 0 -> data written, sb_err=1 until next reset.
REQ-027 Issue to 2, then assert reset while pending -> busyA(2)=0, A(2)=0, sb_err=0 after reset; a following we@2 -> sb_err=1.
